// File: rtl/db_pkg.sv
// Shared definitions for the luma deblocking decision stage.
// Holds the beta'/tc' lookup tables, mode encodings, the 512-bit pixel
// packing constants and the stage-1 decision payload struct.
// Segment packing: line k occupies [128k+127:128k]. Its eight 8-bit pixels
// p3,p2,p1,p0,q0,q1,q2,q3 sit contiguously from the MSB byte down. The low
// 64 bits of each line carry no pixels and are only passed through.
package db_pkg;

  localparam int unsigned DB_PIX_W    = 8;
  localparam int unsigned DB_NUM_LINE = 4;
  localparam int unsigned DB_LINE_W   = 128;
  localparam int unsigned DB_SEG_W    = DB_NUM_LINE * DB_LINE_W;
  localparam int unsigned DB_LINE_PIX = 8;
  localparam int unsigned DB_BETA_W   = 7;
  localparam int unsigned DB_TC_W     = 5;
  localparam int unsigned DB_GRAD_W   = 10;

  typedef enum logic [1:0] {
    DB_MODE_NONE   = 2'd0,
    DB_MODE_NORMAL = 2'd1,
    DB_MODE_STRONG = 2'd2
  } db_mode_e;

  // beta' indexed by Qb = 0..51
  localparam logic [DB_BETA_W-1:0] DB_BETA_LUT [0:51] = '{
    7'd0,  7'd0,  7'd0,  7'd0,  7'd0,  7'd0,  7'd0,  7'd0,
    7'd0,  7'd0,  7'd0,  7'd0,  7'd0,  7'd0,  7'd0,  7'd0,
    7'd6,  7'd7,  7'd8,  7'd9,  7'd10, 7'd11, 7'd12, 7'd13,
    7'd14, 7'd15, 7'd16, 7'd17, 7'd18, 7'd20, 7'd22, 7'd24,
    7'd26, 7'd28, 7'd30, 7'd32, 7'd34, 7'd36, 7'd38, 7'd40,
    7'd42, 7'd44, 7'd46, 7'd48, 7'd50, 7'd52, 7'd54, 7'd56,
    7'd58, 7'd60, 7'd62, 7'd64
  };

  // tc' indexed by Qt = 0..53
  localparam logic [DB_TC_W-1:0] DB_TC_LUT [0:53] = '{
    5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  5'd0,
    5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  5'd0,
    5'd0,  5'd0,  5'd1,  5'd1,  5'd1,  5'd1,  5'd1,  5'd1,
    5'd1,  5'd1,  5'd1,  5'd2,  5'd2,  5'd2,  5'd2,  5'd3,
    5'd3,  5'd3,  5'd3,  5'd4,  5'd4,  5'd4,  5'd5,  5'd5,
    5'd6,  5'd6,  5'd7,  5'd8,  5'd9,  5'd10, 5'd11, 5'd13,
    5'd14, 5'd16, 5'd18, 5'd20, 5'd22, 5'd24
  };

  // Stage-1 decision terms carried alongside the pixels
  typedef struct packed {
    logic [DB_BETA_W-1:0] beta;
    logic [DB_TC_W-1:0]   tc;
    logic [1:0]           bs;
    logic [DB_GRAD_W-1:0] dp0;
    logic [DB_GRAD_W-1:0] dq0;
    logic [DB_GRAD_W-1:0] dp3;
    logic [DB_GRAD_W-1:0] dq3;
`ifdef DB_STRONG_FILTER_EN
    logic [DB_GRAD_W-1:0] far0;
    logic [DB_GRAD_W-1:0] far3;
    logic [DB_PIX_W-1:0]  pq0;
    logic [DB_PIX_W-1:0]  pq3;
`endif
  } db_dec_t;

endpackage

// File: rtl/db_line_grad.sv
// Per-line gradient calculator (combinational).
// Ports:
//   line    : p3,p2,p1,p0,q0,q1,q2,q3 of one line, p3 in the MSB pixel
//   dp, dq  : |p2-2p1+p0|, |q2-2q1+q0|
//   far_sum : |p3-p0|+|q0-q3|   (DB_STRONG_FILTER_EN only)
//   p0q0    : |p0-q0|           (DB_STRONG_FILTER_EN only)
module db_line_grad
  import db_pkg::*;
#(
  parameter int unsigned PIX_W = 8
) (
  input  logic [8*PIX_W-1:0]   line,
  output logic [DB_GRAD_W-1:0] dp,
  output logic [DB_GRAD_W-1:0] dq
`ifdef DB_STRONG_FILTER_EN
  ,
  output logic [DB_GRAD_W-1:0] far_sum,
  output logic [PIX_W-1:0]     p0q0
`endif
);

  // Signed width covering -2*max .. +2*max
  localparam int unsigned SW = PIX_W + 3;

  logic [PIX_W-1:0] p3, p2, p1, p0, q0, q1, q2, q3;
  assign {p3, p2, p1, p0, q0, q1, q2, q3} = line;

  // Second differences, then magnitude
  logic signed [SW-1:0] dp_s, dq_s;
  assign dp_s = $signed(SW'(p2)) - $signed(SW'({p1, 1'b0})) + $signed(SW'(p0));
  assign dq_s = $signed(SW'(q2)) - $signed(SW'({q1, 1'b0})) + $signed(SW'(q0));
  assign dp   = dp_s[SW-1] ? DB_GRAD_W'(-dp_s) : DB_GRAD_W'(dp_s);
  assign dq   = dq_s[SW-1] ? DB_GRAD_W'(-dq_s) : DB_GRAD_W'(dq_s);

`ifdef DB_STRONG_FILTER_EN
  function automatic logic [PIX_W-1:0] absd(input logic [PIX_W-1:0] a,
                                            input logic [PIX_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  assign far_sum = DB_GRAD_W'(absd(p3, p0)) + DB_GRAD_W'(absd(q0, q3));
  assign p0q0    = absd(p0, q0);
`else
  // Outer pixels only feed the strong decision
  logic unused_px;
  assign unused_px = ^{p3, q3};
`endif

endmodule

// File: rtl/db_luma_decision.sv
// Luma deblocking decision stage: 2-deep elastic pipeline.
// S1 computes beta/tc and per-line gradients; the output stage evaluates
// on/off, dEp/dEq and (with DB_STRONG_FILTER_EN) the strong decision.
// Macro DB_STRONG_FILTER_EN: enables strong-filter decision (mode 2).
// Ports:
//   in_valid_i/in_ready_o   : upstream handshake
//   bs_i, qp_p_i, qp_q_i    : boundary strength and block QPs
//   beta/tc_offset_div2_i   : signed slice offsets
//   pix_i                   : 4-line edge segment
//   out_valid_o/out_ready_i : downstream handshake
//   pix_o                   : segment pixels, unchanged
//   tc_o, mode_o, dep_o, deq_o : decision results
module db_luma_decision
  import db_pkg::*;
#(
  parameter int unsigned PIX_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [1:0]          bs_i,
  input  logic [5:0]          qp_p_i,
  input  logic [5:0]          qp_q_i,
  input  logic [3:0]          beta_offset_div2_i,
  input  logic [3:0]          tc_offset_div2_i,
  input  logic [DB_SEG_W-1:0] pix_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [DB_SEG_W-1:0] pix_o,
  output logic [DB_TC_W-1:0]  tc_o,
  output logic [1:0]          mode_o,
  output logic                dep_o,
  output logic                deq_o
);

  localparam int unsigned LINE_PIX_W = DB_LINE_PIX * PIX_W;
  localparam int unsigned L0_MSB     = DB_LINE_W - 1;
  localparam int unsigned L3_MSB     = 4 * DB_LINE_W - 1;

  logic                advance_c;
  logic                s1_valid;
  db_dec_t             s1;
  logic [DB_SEG_W-1:0] s1_pix;
  db_dec_t             dec_c;

  // Handshake
  assign advance_c  = ~out_valid_o | out_ready_i;
  assign in_ready_o = advance_c | ~s1_valid;

  // Line gradients for lines 0 and 3
  db_line_grad #(.PIX_W(PIX_W)) u_grad0 (
    .line    (pix_i[L0_MSB -: LINE_PIX_W]),
    .dp      (dec_c.dp0),
    .dq      (dec_c.dq0)
`ifdef DB_STRONG_FILTER_EN
    ,
    .far_sum (dec_c.far0),
    .p0q0    (dec_c.pq0)
`endif
  );

  db_line_grad #(.PIX_W(PIX_W)) u_grad3 (
    .line    (pix_i[L3_MSB -: LINE_PIX_W]),
    .dp      (dec_c.dp3),
    .dq      (dec_c.dq3)
`ifdef DB_STRONG_FILTER_EN
    ,
    .far_sum (dec_c.far3),
    .p0q0    (dec_c.pq3)
`endif
  );

  // beta/tc table index derivation with clipping
  logic [6:0]        qp_sum_c;
  logic [5:0]        qpl_c;
  logic signed [8:0] qb_s_c;
  logic signed [8:0] qt_s_c;
  logic [5:0]        qb_c;
  logic [5:0]        qt_c;

  assign qp_sum_c = 7'(qp_p_i) + 7'(qp_q_i) + 7'd1;
  assign qpl_c    = qp_sum_c[6:1];
  assign qb_s_c   = $signed({3'b000, qpl_c})
                  + $signed({{4{beta_offset_div2_i[3]}}, beta_offset_div2_i, 1'b0});
  assign qt_s_c   = $signed({3'b000, qpl_c})
                  + $signed({6'b000000, bs_i, 1'b0}) - 9'sd2
                  + $signed({{4{tc_offset_div2_i[3]}}, tc_offset_div2_i, 1'b0});
  assign qb_c     = (qb_s_c < 9'sd0) ? 6'd0 : (qb_s_c > 9'sd51) ? 6'd51 : qb_s_c[5:0];
  assign qt_c     = (qt_s_c < 9'sd0) ? 6'd0 : (qt_s_c > 9'sd53) ? 6'd53 : qt_s_c[5:0];

  assign dec_c.beta = DB_BETA_LUT[qb_c];
  assign dec_c.tc   = DB_TC_LUT[qt_c];
  assign dec_c.bs   = bs_i;

  // Stage 1 registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1       <= '0;
      s1_pix   <= '0;
    end else begin
      if (in_ready_o) s1_valid <= in_valid_i;
      if (in_ready_o && in_valid_i) begin
        s1     <= dec_c;
        s1_pix <= pix_i;
      end
    end
  end

  // Stage 2 decisions
  logic [11:0]   d_c;
  logic          on_c;
  logic [7:0]    side_thr_c;
  logic          dep_c;
  logic          deq_c;
  db_mode_e      mode_c;

  assign d_c        = 12'(s1.dp0) + 12'(s1.dq0) + 12'(s1.dp3) + 12'(s1.dq3);
  assign on_c       = (s1.bs != 2'd0) && (d_c < 12'(s1.beta));
  assign side_thr_c = 8'((8'(s1.beta) + 8'(s1.beta >> 1)) >> 3);
  assign dep_c      = on_c && ((11'(s1.dp0) + 11'(s1.dp3)) < 11'(side_thr_c));
  assign deq_c      = on_c && ((11'(s1.dq0) + 11'(s1.dq3)) < 11'(side_thr_c));

`ifdef DB_STRONG_FILTER_EN
  logic [7:0] tc_lim_c;
  logic       dsam0_c;
  logic       dsam3_c;

  assign tc_lim_c = 8'((8'(s1.tc) * 8'd5 + 8'd1) >> 1);
  assign dsam0_c  = (((12'(s1.dp0) + 12'(s1.dq0)) << 1) < 12'(s1.beta >> 2))
                 && (s1.far0 < DB_GRAD_W'(s1.beta >> 3))
                 && (s1.pq0 < tc_lim_c);
  assign dsam3_c  = (((12'(s1.dp3) + 12'(s1.dq3)) << 1) < 12'(s1.beta >> 2))
                 && (s1.far3 < DB_GRAD_W'(s1.beta >> 3))
                 && (s1.pq3 < tc_lim_c);
`endif

  // Mode selection
  always_comb begin
    mode_c = DB_MODE_NONE;
    if (on_c) mode_c = DB_MODE_NORMAL;
`ifdef DB_STRONG_FILTER_EN
    if (on_c && dsam0_c && dsam3_c) mode_c = DB_MODE_STRONG;
`endif
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_o <= 1'b0;
      pix_o       <= '0;
      tc_o        <= '0;
      mode_o      <= 2'd0;
      dep_o       <= 1'b0;
      deq_o       <= 1'b0;
    end else if (advance_c) begin
      out_valid_o <= s1_valid;
      if (s1_valid) begin
        pix_o  <= s1_pix;
        tc_o   <= on_c ? s1.tc : '0;
        mode_o <= mode_c;
        dep_o  <= dep_c;
        deq_o  <= deq_c;
      end
    end
  end

endmodule

// File: tb/tb_db_luma_decision.sv
// Directed self-checking bench for db_luma_decision.
module tb_db_luma_decision;

`ifdef DB_STRONG_FILTER_EN
  localparam logic [1:0] EXP_STRONG = 2'd2;
`else
  localparam logic [1:0] EXP_STRONG = 2'd1;
`endif

  logic         clk, rst_n;
  logic         in_valid_i, in_ready_o;
  logic [1:0]   bs_i;
  logic [5:0]   qp_p_i, qp_q_i;
  logic [3:0]   beta_offset_div2_i, tc_offset_div2_i;
  logic [511:0] pix_i;
  logic         out_valid_o, out_ready_i;
  logic [511:0] pix_o;
  logic [4:0]   tc_o;
  logic [1:0]   mode_o;
  logic         dep_o, deq_o;

  int total = 0;
  int bad   = 0;

  db_luma_decision dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .in_valid_i         (in_valid_i),
    .in_ready_o         (in_ready_o),
    .bs_i               (bs_i),
    .qp_p_i             (qp_p_i),
    .qp_q_i             (qp_q_i),
    .beta_offset_div2_i (beta_offset_div2_i),
    .tc_offset_div2_i   (tc_offset_div2_i),
    .pix_i              (pix_i),
    .out_valid_o        (out_valid_o),
    .out_ready_i        (out_ready_i),
    .pix_o              (pix_o),
    .tc_o               (tc_o),
    .mode_o             (mode_o),
    .dep_o              (dep_o),
    .deq_o              (deq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [511:0] mk_flat(input logic [7:0] v);
    return {64{v}};
  endfunction

  // idx: 0=p3,1=p2,2=p1,3=p0,4=q0,5=q1,6=q2,7=q3
  function automatic logic [511:0] set_px(input logic [511:0] pix, input int line,
                                          input int idx, input logic [7:0] v);
    logic [511:0] r;
    r = pix;
    r[128*line + 127 - 8*idx -: 8] = v;
    return r;
  endfunction

  // Drive one segment into an idle pipe and capture its result
  task automatic run_seg(input logic [1:0] bs, input logic [5:0] qpp, input logic [5:0] qpq,
                         input logic [3:0] bo, input logic [3:0] to, input logic [511:0] pix,
                         output logic [511:0] opix, output logic [4:0] otc,
                         output logic [1:0] omode, output logic odep, output logic odeq,
                         output int lat);
    @(negedge clk);
    bs_i = bs; qp_p_i = qpp; qp_q_i = qpq;
    beta_offset_div2_i = bo; tc_offset_div2_i = to;
    pix_i = pix; in_valid_i = 1'b1; out_ready_i = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      in_valid_i = 1'b0;
      lat++;
    end while (!out_valid_o && lat < 10);
    opix = pix_o; otc = tc_o; omode = mode_o; odep = dep_o; odeq = deq_o;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid_o); end
    total++; if (in_ready_o !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready_o); end
    total++; if (pix_o !== 512'd0) begin bad++; $display("FAIL rst_pix got=%h exp=0", pix_o); end
    total++; if ({tc_o, mode_o, dep_o, deq_o} !== 9'd0) begin bad++;
      $display("FAIL rst_dec got tc=%0d mode=%0d dep=%b deq=%b exp all 0", tc_o, mode_o, dep_o, deq_o); end
  endtask

  task automatic test_flat();
    logic [511:0] op; logic [4:0] t; logic [1:0] m; logic dp, dq; int lat;
    run_seg(2'd2, 6'd37, 6'd37, 4'd0, 4'd0, mk_flat(8'd128), op, t, m, dp, dq, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL flat_latency got=%0d exp=2", lat); end
    total++; if (t !== 5'd5) begin bad++; $display("FAIL flat_tc got=%0d exp=5", t); end
    total++; if (m !== EXP_STRONG) begin bad++; $display("FAIL flat_mode got=%0d exp=%0d", m, EXP_STRONG); end
    total++; if ({dp, dq} !== 2'b11) begin bad++; $display("FAIL flat_depq got=%b%b exp=11", dp, dq); end
    total++; if (op !== mk_flat(8'd128)) begin bad++; $display("FAIL flat_pix got=%h", op); end
  endtask

  task automatic test_bs0();
    logic [511:0] op, px; logic [4:0] t; logic [1:0] m; logic dp, dq; int lat;
    px = set_px(mk_flat(8'd128), 2, 5, 8'd77);
    run_seg(2'd0, 6'd37, 6'd37, 4'd0, 4'd0, px, op, t, m, dp, dq, lat);
    total++; if ({t, m, dp, dq} !== 9'd0) begin bad++;
      $display("FAIL bs0_dec got tc=%0d mode=%0d dep=%b deq=%b exp all 0", t, m, dp, dq); end
    total++; if (op !== px) begin bad++; $display("FAIL bs0_pix got=%h exp=%h", op, px); end
  endtask

  task automatic test_ramp();
    logic [511:0] op, px; logic [4:0] t; logic [1:0] m; logic dp, dq; int lat;
    px = mk_flat(8'd130);
    for (int l = 0; l < 4; l++) begin
      px = set_px(px, l, 0, 8'd100);
      px = set_px(px, l, 1, 8'd110);
      px = set_px(px, l, 2, 8'd120);
    end
    run_seg(2'd1, 6'd37, 6'd37, 4'd0, 4'd0, px, op, t, m, dp, dq, lat);
    total++; if (t !== 5'd4) begin bad++; $display("FAIL ramp_tc got=%0d exp=4", t); end
    total++; if (m !== 2'd1) begin bad++; $display("FAIL ramp_mode got=%0d exp=1", m); end
    total++; if ({dp, dq} !== 2'b11) begin bad++; $display("FAIL ramp_depq got=%b%b exp=11", dp, dq); end
  endtask

  task automatic test_qp_clip();
    logic [511:0] op; logic [4:0] t; logic [1:0] m; logic dp, dq; int lat;
    // beta = 0 at qp 10
    run_seg(2'd2, 6'd10, 6'd10, 4'd0, 4'd0, mk_flat(8'd128), op, t, m, dp, dq, lat);
    total++; if ({t, m} !== 7'd0) begin bad++; $display("FAIL lowqp got tc=%0d mode=%0d exp 0/0", t, m); end
    // Qb -> 51 (beta 64), Qt -> 53 (tc 24)
    run_seg(2'd2, 6'd51, 6'd51, 4'd6, 4'd6, mk_flat(8'd128), op, t, m, dp, dq, lat);
    total++; if (t !== 5'd24) begin bad++; $display("FAIL hiclip_tc got=%0d exp=24", t); end
    total++; if (m !== EXP_STRONG) begin bad++; $display("FAIL hiclip_mode got=%0d exp=%0d", m, EXP_STRONG); end
    // negative offsets clip to 0
    run_seg(2'd1, 6'd0, 6'd0, 4'hA, 4'hA, mk_flat(8'd128), op, t, m, dp, dq, lat);
    total++; if ({t, m} !== 7'd0) begin bad++; $display("FAIL loclip got tc=%0d mode=%0d exp 0/0", t, m); end
    // tc offset -2: Qt 35 -> tc 4
    run_seg(2'd2, 6'd37, 6'd37, 4'd0, 4'hE, mk_flat(8'd128), op, t, m, dp, dq, lat);
    total++; if (t !== 5'd4) begin bad++; $display("FAIL tcoff_tc got=%0d exp=4", t); end
  endtask

  // d = beta is off; d = beta-2 is on with only dEq
  task automatic test_d_boundary();
    logic [511:0] op, px; logic [4:0] t; logic [1:0] m; logic dp, dq; int lat;
    px = set_px(set_px(mk_flat(8'd128), 0, 1, 8'd146), 3, 1, 8'd146);
    run_seg(2'd2, 6'd37, 6'd37, 4'd0, 4'd0, px, op, t, m, dp, dq, lat);
    total++; if ({t, m, dp, dq} !== 9'd0) begin bad++;
      $display("FAIL d_eq_beta got tc=%0d mode=%0d dep=%b deq=%b exp all 0", t, m, dp, dq); end
    px = set_px(set_px(mk_flat(8'd128), 0, 1, 8'd145), 3, 1, 8'd145);
    run_seg(2'd2, 6'd37, 6'd37, 4'd0, 4'd0, px, op, t, m, dp, dq, lat);
    total++; if (m !== 2'd1) begin bad++; $display("FAIL d_lt_beta_mode got=%0d exp=1", m); end
    total++; if (t !== 5'd5) begin bad++; $display("FAIL d_lt_beta_tc got=%0d exp=5", t); end
    total++; if ({dp, dq} !== 2'b01) begin bad++; $display("FAIL d_lt_beta_depq got=%b%b exp=01", dp, dq); end
  endtask

  task automatic test_back_to_back();
    int sent, recv, cyc;
    logic exp_rdy;
    sent = 0; recv = 0; cyc = 0;
    bs_i = 2'd2; qp_p_i = 6'd37; qp_q_i = 6'd37;
    beta_offset_div2_i = 4'd0; tc_offset_div2_i = 4'd0;
    while (recv < 8 && cyc < 200) begin
      @(negedge clk);
      out_ready_i = (cyc % 3 == 0);
      in_valid_i  = (sent < 8);
      pix_i       = mk_flat(8'(40 + sent * 20));
      #1;
      exp_rdy = !((sent - recv) == 2 && !out_ready_i);
      total++; if (in_ready_o !== exp_rdy) begin bad++;
        $display("FAIL b2b_ready cyc=%0d got=%b exp=%b", cyc, in_ready_o, exp_rdy); end
      if (out_valid_o && out_ready_i) begin
        total++; if (pix_o !== mk_flat(8'(40 + recv * 20))) begin bad++;
          $display("FAIL b2b_pix idx=%0d got=%h", recv, pix_o); end
        total++; if (mode_o !== EXP_STRONG || tc_o !== 5'd5) begin bad++;
          $display("FAIL b2b_dec idx=%0d got mode=%0d tc=%0d exp mode=%0d tc=5", recv, mode_o, tc_o, EXP_STRONG); end
        recv++;
      end
      if (in_valid_i && in_ready_o) sent++;
      cyc++;
    end
    total++; if (recv !== 8) begin bad++; $display("FAIL b2b_count got=%0d exp=8", recv); end
    @(negedge clk);
    in_valid_i = 1'b0; out_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL b2b_extra got=%b exp=0", out_valid_o); end
  endtask

  task automatic test_reset_midflight();
    logic [511:0] op; logic [4:0] t; logic [1:0] m; logic dp, dq; int lat;
    @(negedge clk);
    bs_i = 2'd2; qp_p_i = 6'd37; qp_q_i = 6'd37;
    beta_offset_div2_i = 4'd0; tc_offset_div2_i = 4'd0;
    out_ready_i = 1'b0; in_valid_i = 1'b1; pix_i = mk_flat(8'd11);
    @(negedge clk);
    pix_i = mk_flat(8'd22);
    @(negedge clk);
    in_valid_i = 1'b0;
    total++; if (out_valid_o !== 1'b1) begin bad++; $display("FAIL mid_loaded got=%b exp=1", out_valid_o); end
    rst_n = 1'b0;
    #1;
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b exp=0", out_valid_o); end
    total++; if (pix_o !== 512'd0 || mode_o !== 2'd0) begin bad++;
      $display("FAIL mid_rst_payload got mode=%0d pix=%h exp 0", mode_o, pix_o); end
    @(negedge clk);
    rst_n = 1'b1; out_ready_i = 1'b1;
    @(negedge clk);
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL mid_post_empty got=%b exp=0", out_valid_o); end
    run_seg(2'd2, 6'd37, 6'd37, 4'd0, 4'd0, mk_flat(8'd33), op, t, m, dp, dq, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL mid_post_latency got=%0d exp=2", lat); end
    total++; if (op !== mk_flat(8'd33)) begin bad++; $display("FAIL mid_post_pix got=%h", op); end
  endtask

  initial begin
    rst_n = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    bs_i = 2'd0; qp_p_i = 6'd0; qp_q_i = 6'd0;
    beta_offset_div2_i = 4'd0; tc_offset_div2_i = 4'd0; pix_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_flat();
    test_bs0();
    test_ramp();
    test_qp_clip();
    test_d_boundary();
    test_back_to_back();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
